// File: rtl/cla_adder_16.sv
// 16-bit two-level carry-lookahead adder built from explicit gate equations,
// with a registered sum/carry_out stage and asynchronous active-low reset.
module cla_adder_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out
);

    logic [15:0] p;
    logic [15:0] g;
    logic [16:0] c;
    logic [3:0]  blk_p;
    logic [3:0]  blk_g;
    logic [15:0] sum_d;
    logic        carry_d;
    logic [15:0] sum_q;
    logic        carry_q;

    assign p = a ^ b;
    assign g = a & b;
    assign c[0] = carry_in;

    // First level: each 4-bit block derives c1..c3 from its own carry-in, no ripple.
    for (genvar j = 0; j < 4; j++) begin : g_blk
        localparam int K = 4 * j;

        assign c[K+1] = g[K]
                      | (p[K] & c[K]);
        assign c[K+2] = g[K+1]
                      | (p[K+1] & g[K])
                      | (p[K+1] & p[K] & c[K]);
        assign c[K+3] = g[K+2]
                      | (p[K+2] & g[K+1])
                      | (p[K+2] & p[K+1] & g[K])
                      | (p[K+2] & p[K+1] & p[K] & c[K]);

        assign blk_p[j] = p[K+3] & p[K+2] & p[K+1] & p[K];
        assign blk_g[j] = g[K+3]
                        | (p[K+3] & g[K+2])
                        | (p[K+3] & p[K+2] & g[K+1])
                        | (p[K+3] & p[K+2] & p[K+1] & g[K]);
    end

    // Second level: block carry-ins straight from carry_in, never from c[4*j].
    assign c[4]  = blk_g[0]
                 | (blk_p[0] & carry_in);
    assign c[8]  = blk_g[1]
                 | (blk_p[1] & blk_g[0])
                 | (blk_p[1] & blk_p[0] & carry_in);
    assign c[12] = blk_g[2]
                 | (blk_p[2] & blk_g[1])
                 | (blk_p[2] & blk_p[1] & blk_g[0])
                 | (blk_p[2] & blk_p[1] & blk_p[0] & carry_in);
    assign c[16] = blk_g[3]
                 | (blk_p[3] & blk_g[2])
                 | (blk_p[3] & blk_p[2] & blk_g[1])
                 | (blk_p[3] & blk_p[2] & blk_p[1] & blk_g[0])
                 | (blk_p[3] & blk_p[2] & blk_p[1] & blk_p[0] & carry_in);

    assign sum_d   = p ^ c[15:0];
    assign carry_d = c[16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_cla_adder_16.sv
// Self-checking bench for cla_adder_16: directed cases plus a random sweep
// against a 17-bit arithmetic reference with one cycle of latency.
module tb_cla_adder_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic [15:0] sum;
    logic        carry_out;

    int unsigned n_tests;
    int unsigned n_fail;

    cla_adder_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one operand set just after an edge, then check it one edge later.
    task automatic apply_exp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                             input logic cv, input logic [16:0] exp);
        a        = av;
        b        = bv;
        carry_in = cv;
        @(posedge clk);
        #1;
        check_val(tag, {carry_out, sum}, exp);
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] av, input logic [15:0] bv,
                                            input logic cv);
        int unsigned t;
        t = int'(av) + int'(bv) + int'(cv);
        return t[16:0];
    endfunction

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a        = 16'd10;
        b        = 16'd22;
        carry_in = 1'b0;

        #1;
        check_val("reset_async", {carry_out, sum}, 17'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_hold", {carry_out, sum}, 17'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_release", {carry_out, sum}, 17'd32);

        apply_exp("b2b_120_82",  16'd120, 16'd82,  1'b0, 17'd202);
        apply_exp("b2b_928_910", 16'd928, 16'd910, 1'b1, 17'd1839);

        // Output must hold while inputs change between edges.
        a = 16'h1234;
        b = 16'h4321;
        #3;
        check_val("hold_between_edges", {carry_out, sum}, 17'd1839);

        rst_n = 1'b0;
        #1;
        check_val("midstream_reset", {carry_out, sum}, 17'd0);
        @(posedge clk);
        #1;
        check_val("midstream_reset_hold", {carry_out, sum}, 17'd0);
        rst_n = 1'b1;

        apply_exp("b2b_7_1",        16'd7,     16'd1,     1'b1, 17'd9);
        apply_exp("prop_cin1",      16'hAAAA,  16'h5555,  1'b1, 17'h10000);
        apply_exp("prop_cin0",      16'hAAAA,  16'h5555,  1'b0, 17'h0FFFF);
        apply_exp("ovf_ffff_1",     16'hFFFF,  16'd1,     1'b0, 17'h10000);
        apply_exp("ovf_ffff_ffff",  16'hFFFF,  16'hFFFF,  1'b1, 17'h1FFFF);
        apply_exp("zero",           16'd0,     16'd0,     1'b0, 17'd0);
        apply_exp("grp_c4",         16'h000F,  16'd1,     1'b0, 17'h00010);
        apply_exp("grp_c8",         16'h00FF,  16'd1,     1'b0, 17'h00100);
        apply_exp("grp_c12",        16'h0FFF,  16'd1,     1'b0, 17'h01000);
        apply_exp("cin_only_c16",   16'hFFFF,  16'd0,     1'b1, 17'h10000);

        for (int i = 0; i < 1200; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            // Bias some vectors towards long propagate chains.
            if (i % 8 == 0) rb = ~ra;
            apply_exp("random", ra, rb, rc, ref_add(ra, rb, rc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
